// File: rtl/airi5c_src_b_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : airi5c_src_b_stage_pkg                                          |
// | Purpose  : Operand-B select encodings and default widths for src_b stage   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package airi5c_src_b_stage_pkg;

    localparam int XPR_LEN         = 32;
    localparam int SRC_B_SEL_WIDTH = 2;

    typedef enum logic [SRC_B_SEL_WIDTH-1:0] {
        SRC_B_RS2  = 2'd0,
        SRC_B_IMM  = 2'd1,
        SRC_B_FOUR = 2'd2,
        SRC_B_ZERO = 2'd3
    } src_b_sel_e;

endpackage
`default_nettype wire

// File: rtl/airi5c_src_b_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : airi5c_src_b_stage_if                                           |
// | Purpose  : DX request, forwarding and EX handshake bundle of src_b stage   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface airi5c_src_b_stage_if
    import airi5c_src_b_stage_pkg::*;
#(
    parameter int XLEN    = XPR_LEN,
    parameter int NUM_FWD = 2,
    parameter int REG_AW  = 5
);
    logic                        flush;
    logic                        in_valid;
    logic                        in_ready;
    logic [SRC_B_SEL_WIDTH-1:0]  src_b_sel;
    logic                        was_compressed;
    logic [XLEN-1:0]             imm;
    logic [REG_AW-1:0]           rs2_addr;
    logic [XLEN-1:0]             rs2_data;
    logic [NUM_FWD-1:0]          fwd_valid;
    logic [NUM_FWD*REG_AW-1:0]   fwd_addr;
    logic [NUM_FWD*XLEN-1:0]     fwd_data;
    logic [XLEN-1:0]             alu_src_b;
    logic                        out_valid;
    logic                        out_ready;
    logic                        fwd_hit;

    modport master (
        output flush, in_valid, src_b_sel, was_compressed, imm, rs2_addr, rs2_data,
               fwd_valid, fwd_addr, fwd_data, out_ready,
        input  in_ready, alu_src_b, out_valid, fwd_hit
    );

    modport slave (
        input  flush, in_valid, src_b_sel, was_compressed, imm, rs2_addr, rs2_data,
               fwd_valid, fwd_addr, fwd_data, out_ready,
        output in_ready, alu_src_b, out_valid, fwd_hit
    );

endinterface
`default_nettype wire

// File: rtl/airi5c_fwd_select.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : airi5c_fwd_select                                               |
// | Purpose  : Priority match of rs2 against in-flight results (index 0 wins)  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module airi5c_fwd_select #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2,
    parameter int REG_AW  = 5
) (
    input  wire logic [REG_AW-1:0]         rs2_addr,
    input  wire logic [XLEN-1:0]           rs2_data,
    input  wire logic [NUM_FWD-1:0]        fwd_valid,
    input  wire logic [NUM_FWD*REG_AW-1:0] fwd_addr,
    input  wire logic [NUM_FWD*XLEN-1:0]   fwd_data,
    output logic      [XLEN-1:0]           data,
    output logic                           hit
);

    // Scan from the oldest source down so the youngest match overwrites last.
    always_comb begin
        data = rs2_data;
        hit  = 1'b0;
        if (rs2_addr != '0) begin
            for (int i = NUM_FWD - 1; i >= 0; i--) begin
                if (fwd_valid[i] && (fwd_addr[i*REG_AW +: REG_AW] == rs2_addr)) begin
                    data = fwd_data[i*XLEN +: XLEN];
                    hit  = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/airi5c_src_b_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : airi5c_src_b_stage                                              |
// | Purpose  : Registered ALU operand-B select with forwarding and flush.      |
// |            Forwarding enabled by defining AIRI5C_SRC_B_FWD_EN.             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module airi5c_src_b_stage
    import airi5c_src_b_stage_pkg::*;
#(
    parameter int XLEN    = XPR_LEN,
    parameter int NUM_FWD = 2,
    parameter int REG_AW  = 5
) (
    input wire logic              clk_i,
    input wire logic              rst_i,
    airi5c_src_b_stage_if.slave   bus
);

    logic [XLEN-1:0] r_data;
    logic            r_valid;
    logic            r_hit;
    logic [XLEN-1:0] w_rs2_data;
    logic            w_rs2_hit;
    logic [XLEN-1:0] w_sel_data;
    logic            w_sel_hit;
    logic            w_in_ready;
    logic            w_accept;

`ifdef AIRI5C_SRC_B_FWD_EN
    airi5c_fwd_select #(
        .XLEN    (XLEN),
        .NUM_FWD (NUM_FWD),
        .REG_AW  (REG_AW)
    ) u_fwd_select (
        .rs2_addr  (bus.rs2_addr),
        .rs2_data  (bus.rs2_data),
        .fwd_valid (bus.fwd_valid),
        .fwd_addr  (bus.fwd_addr),
        .fwd_data  (bus.fwd_data),
        .data      (w_rs2_data),
        .hit       (w_rs2_hit)
    );
`else
    logic [NUM_FWD*(1+REG_AW+XLEN)-1:0] unused_fwd;
    logic [REG_AW-1:0]                  unused_rs2_addr;

    assign unused_fwd      = {bus.fwd_valid, bus.fwd_addr, bus.fwd_data};
    assign unused_rs2_addr = bus.rs2_addr;
    assign w_rs2_data      = bus.rs2_data;
    assign w_rs2_hit       = 1'b0;
`endif

    always_comb begin
        w_sel_data = '0;
        w_sel_hit  = 1'b0;
        case (bus.src_b_sel)
            SRC_B_RS2: begin
                w_sel_data = w_rs2_data;
                w_sel_hit  = w_rs2_hit;
            end
            SRC_B_IMM:  w_sel_data = bus.imm;
            SRC_B_FOUR: w_sel_data = bus.was_compressed ? XLEN'(2) : XLEN'(4);
            default:    w_sel_data = '0;
        endcase
    end

    assign w_in_ready = !r_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready && !bus.flush;

    // Flush outranks accept; a stalled entry keeps its data and hit flag untouched.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_hit   <= 1'b0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_data  <= w_sel_data;
            r_hit   <= w_sel_hit;
        end else if (bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_valid;
    assign bus.alu_src_b = r_data;
    assign bus.fwd_hit   = r_hit;

endmodule
`default_nettype wire
